// File: rtl/trap_ctrl_pkg.sv
// Shared core definitions for the trap sequencer: CSR addresses, system opcodes,
// trap causes, mstatus bit positions and the sequencer state type.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;
  localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;

  localparam int unsigned MIE_BIT  = 3;
  localparam int unsigned MPIE_BIT = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE_MEPC,
    ST_SAVE_MCAUSE,
    ST_SAVE_MSTATUS,
    ST_RESTORE_MSTATUS,
    ST_REDIRECT
  } state_t;

  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] m);
    logic [31:0] r;
    r           = m;
    r[MPIE_BIT] = m[MIE_BIT];
    r[MIE_BIT]  = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] m);
    logic [31:0] r;
    r           = m;
    r[MIE_BIT]  = m[MPIE_BIT];
    r[MPIE_BIT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Trap/interrupt sequencer: freezes the pipeline, saves/restores M-mode CSRs, then redirects.
// Latency: trap = 3 CSR writes then redirect at N+4; mret = 1 write then redirect at N+2.
// Backpressure: none accepted; hold_flag_o asserts combinationally from the detecting cycle.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic [7:0]  int_flag_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        hold_flag_o,
  output logic        we_o,
  output logic [11:0] waddr_o,
  output logic [31:0] data_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  state_t      state_q, state_d;
  logic [31:0] ret_pc_q, cause_q;
  logic        mret_q;

  logic        can_detect, det_trap, det_mret;
  logic [31:0] det_pc, det_cause;

  // Synchronous traps outrank interrupts; detection is suppressed while in reset.
  always_comb begin
    can_detect = (state_q == ST_IDLE) && !rst;
    det_trap   = 1'b0;
    det_mret   = 1'b0;
    det_pc     = inst_addr_i;
    det_cause  = CAUSE_ECALL;
    if (can_detect) begin
      if (inst_i == INST_ECALL) begin
        det_trap = 1'b1;
      end else if (inst_i == INST_EBREAK) begin
        det_trap  = 1'b1;
        det_cause = CAUSE_EBREAK;
      end else if (inst_i == INST_MRET) begin
        det_mret = 1'b1;
      end else if ((|int_flag_i) && csr_mstatus_i[MIE_BIT]) begin
        det_trap  = 1'b1;
        det_cause = int_flag_i[0] ? CAUSE_TIMER : CAUSE_EXT;
        det_pc    = jump_en_i ? jump_addr_i : inst_addr_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ret_pc_q <= '0;
      cause_q  <= '0;
      mret_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (det_trap) begin
        ret_pc_q <= det_pc;
        cause_q  <= det_cause;
        mret_q   <= 1'b0;
      end else if (det_mret) begin
        mret_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (det_trap)      state_d = ST_SAVE_MEPC;
        else if (det_mret) state_d = ST_RESTORE_MSTATUS;
      end
      ST_SAVE_MEPC:       state_d = ST_SAVE_MCAUSE;
      ST_SAVE_MCAUSE:     state_d = ST_SAVE_MSTATUS;
      ST_SAVE_MSTATUS:    state_d = ST_REDIRECT;
      ST_RESTORE_MSTATUS: state_d = ST_REDIRECT;
      ST_REDIRECT:        state_d = ST_IDLE;
      default:            state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    hold_flag_o  = (state_q != ST_IDLE) || det_trap || det_mret;
    we_o         = 1'b0;
    waddr_o      = '0;
    data_o       = '0;
    int_assert_o = 1'b0;
    int_addr_o   = RESET_ADDR;
    unique case (state_q)
      ST_SAVE_MEPC: begin
        we_o    = 1'b1;
        waddr_o = CSR_MEPC;
        data_o  = ret_pc_q;
      end
      ST_SAVE_MCAUSE: begin
        we_o    = 1'b1;
        waddr_o = CSR_MCAUSE;
        data_o  = cause_q;
      end
      ST_SAVE_MSTATUS: begin
        we_o    = 1'b1;
        waddr_o = CSR_MSTATUS;
        data_o  = mstatus_on_trap(csr_mstatus_i);
      end
      ST_RESTORE_MSTATUS: begin
        we_o    = 1'b1;
        waddr_o = CSR_MSTATUS;
        data_o  = mstatus_on_mret(csr_mstatus_i);
      end
      ST_REDIRECT: begin
        int_assert_o = 1'b1;
        int_addr_o   = mret_q ? csr_mepc_i : {csr_mtvec_i[31:2], 2'b00};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed then randomized checks of trap_ctrl against a cycle-schedule reference model.
module tb_trap_ctrl;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  // Scheduled per-cycle actions of the reference model.
  localparam int K_WR      = 0;  // write fixed value
  localparam int K_MS_TRAP = 1;  // mstatus write, trap transform of current input
  localparam int K_MS_MRET = 2;  // mstatus write, mret transform of current input
  localparam int K_RD_TVEC = 3;  // redirect to aligned mtvec
  localparam int K_RD_EPC  = 4;  // redirect to mepc

  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [31:0] val;
  } act_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i;
  logic        jump_en_i;
  logic [7:0]  int_flag_i;
  logic [31:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic        hold_flag_o, we_o, int_assert_o;
  logic [11:0] waddr_o;
  logic [31:0] data_o, int_addr_o;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  act_t sched[$];

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i), .int_flag_i(int_flag_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .hold_flag_o(hold_flag_o), .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o),
    .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic act_t mk(input int k, input logic [11:0] a, input logic [31:0] v);
    act_t r;
    r.kind = k; r.addr = a; r.val = v;
    return r;
  endfunction

  task automatic push_trap(input logic [31:0] cause, input logic [31:0] pc);
    sched.push_back(mk(K_WR, 12'h341, pc));
    sched.push_back(mk(K_WR, 12'h342, cause));
    sched.push_back(mk(K_MS_TRAP, 12'h300, 32'h0));
    sched.push_back(mk(K_RD_TVEC, 12'h000, 32'h0));
  endtask

  // One clock: compare outputs mid-cycle against the model, advance the model, cross the edge.
  task automatic step();
    logic        e_hold, e_we, e_as, detect;
    logic [11:0] e_wa;
    logic [31:0] e_d, e_ia, m;
    @(negedge clk);
    e_we = 1'b0; e_wa = '0; e_d = '0; e_as = 1'b0; e_ia = RST_PC; detect = 1'b0;
    m = csr_mstatus_i;
    if (sched.size() > 0) begin
      case (sched[0].kind)
        K_WR:      begin e_we = 1'b1; e_wa = sched[0].addr; e_d = sched[0].val; end
        K_MS_TRAP: begin e_we = 1'b1; e_wa = 12'h300; e_d = m; e_d[7] = m[3]; e_d[3] = 1'b0; end
        K_MS_MRET: begin e_we = 1'b1; e_wa = 12'h300; e_d = m; e_d[3] = m[7]; e_d[7] = 1'b1; end
        K_RD_TVEC: begin e_as = 1'b1; e_ia = csr_mtvec_i & 32'hFFFF_FFFC; end
        default:   begin e_as = 1'b1; e_ia = csr_mepc_i; end
      endcase
    end else if (!rst) begin
      detect = (inst_i == ECALL) || (inst_i == EBREAK) || (inst_i == MRET) ||
               ((int_flag_i != 8'h0) && m[3]);
    end
    e_hold = (sched.size() > 0) || detect;
    chk("hold", {31'h0, hold_flag_o}, {31'h0, e_hold});
    chk("we", {31'h0, we_o}, {31'h0, e_we});
    chk("waddr", {20'h0, waddr_o}, {20'h0, e_wa});
    chk("data", data_o, e_d);
    chk("int_assert", {31'h0, int_assert_o}, {31'h0, e_as});
    chk("int_addr", int_addr_o, e_ia);
    if (rst) sched.delete();
    else if (sched.size() > 0) void'(sched.pop_front());
    else if (detect) begin
      if (inst_i == ECALL) push_trap(32'd11, inst_addr_i);
      else if (inst_i == EBREAK) push_trap(32'd3, inst_addr_i);
      else if (inst_i == MRET) begin
        sched.push_back(mk(K_MS_MRET, 12'h300, 32'h0));
        sched.push_back(mk(K_RD_EPC, 12'h000, 32'h0));
      end else
        push_trap(int_flag_i[0] ? 32'h8000_0007 : 32'h8000_000B,
                  jump_en_i ? jump_addr_i : inst_addr_i);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; inst_i = NOP; inst_addr_i = 32'h0; jump_en_i = 1'b0; jump_addr_i = 32'h0;
    int_flag_i = 8'h0; csr_mtvec_i = 32'h200; csr_mepc_i = 32'h0; csr_mstatus_i = 32'h8;
    @(posedge clk); #1;
    step(); step();  // reset state with rst held
    rst = 1'b0;

    // ecall at 0x100
    inst_i = ECALL; inst_addr_i = 32'h100; step();
    inst_i = NOP; repeat (6) step();

    // mret
    csr_mepc_i = 32'h104; csr_mstatus_i = 32'h80; inst_i = MRET; step();
    inst_i = NOP; repeat (4) step();

    // timer interrupt with a pending EX jump
    csr_mstatus_i = 32'h8; int_flag_i = 8'h01; jump_en_i = 1'b1; jump_addr_i = 32'h300;
    inst_addr_i = 32'h140; step();
    int_flag_i = 8'h0; jump_en_i = 1'b0; repeat (6) step();

    // masked external interrupt, then unmasked
    csr_mstatus_i = 32'h0; int_flag_i = 8'h04; repeat (3) step();
    csr_mstatus_i = 32'h8; step();
    int_flag_i = 8'h0; repeat (6) step();

    // ebreak beats a simultaneous timer interrupt that stays pending
    inst_i = EBREAK; int_flag_i = 8'h01; inst_addr_i = 32'h180; step();
    inst_i = NOP; repeat (4) step();
    int_flag_i = 8'h0; csr_mstatus_i = 32'h80; repeat (6) step();

    // reset in the middle of a trap
    csr_mstatus_i = 32'h8; inst_i = ECALL; inst_addr_i = 32'h1c0; step();
    inst_i = NOP; step();
    rst = 1'b1; step();
    rst = 1'b0; repeat (4) step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0:       inst_i = ECALL;
        1:       inst_i = EBREAK;
        2:       inst_i = MRET;
        default: inst_i = $urandom();
      endcase
      inst_addr_i   = $urandom();
      jump_en_i     = 1'($urandom_range(0, 1));
      jump_addr_i   = $urandom();
      int_flag_i    = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'h0;
      csr_mtvec_i   = $urandom();
      csr_mepc_i    = $urandom();
      csr_mstatus_i = $urandom();
      rst           = ($urandom_range(0, 40) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Core-local trap/interrupt sequencer: detects ecall/ebreak/mret from the decode stage and pending external/timer interrupts, freezes the pipeline through the hold-request input of `control`, performs the machine-mode CSR save/restore sequence over a dedicated CSR write port, then issues a redirect (`int_assert_o`/`int_addr_o`) that `control` merges into the jump path. It is the requesting end of the hold/jump protocol that `control` consumes.

## Interface
- `RESET_ADDR`, 32'h0000_0000: value driven on `int_addr_o` when idle.
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `inst_i` in 32: instruction currently in ID.
- `inst_addr_i` in 32: PC of `inst_i`.
- `jump_en_i` in 1: EX redirect this cycle.
- `jump_addr_i` in 32: EX redirect target.
- `int_flag_i` in 8: level interrupt requests; bit0 timer, bits[7:1] external.
- `csr_mtvec_i`, `csr_mepc_i`, `csr_mstatus_i` in 32 each: current CSR values.
- `hold_flag_o` out 1: hold request to `control`.
- `we_o` out 1: CSR write enable.
- `waddr_o` out 12: CSR write address.
- `data_o` out 32: CSR write data.
- `int_assert_o` out 1: one-cycle redirect strobe.
- `int_addr_o` out 32: redirect target.

## Operation
- States: IDLE, SAVE_MEPC, SAVE_MCAUSE, SAVE_MSTATUS, RESTORE_MSTATUS, REDIRECT.
- Detection (IDLE only), priority high to low:
  - `inst_i`==32'h0000_0073 (ecall): cause 11, return PC `inst_addr_i`.
  - `inst_i`==32'h0010_0073 (ebreak): cause 3, return PC `inst_addr_i`.
  - `inst_i`==32'h3020_0073 (mret): go to RESTORE_MSTATUS.
  - `|int_flag_i` and `csr_mstatus_i[3]` (MIE): cause 32'h8000_0007 if bit0 set, else 32'h8000_000B; return PC is `jump_addr_i` if `jump_en_i`, else `inst_addr_i`.
- Trap path: IDLE -> SAVE_MEPC (write 0x341 = return PC) -> SAVE_MCAUSE (write 0x342 = cause) -> SAVE_MSTATUS (write 0x300 = mstatus with bit7 MPIE = old bit3, bit3 = 0) -> REDIRECT (`int_addr_o` = {`csr_mtvec_i`[31:2], 2'b00}) -> IDLE.
- mret path: IDLE -> RESTORE_MSTATUS (write 0x300 = mstatus with bit3 = old bit7, bit7 = 1) -> REDIRECT (`int_addr_o` = `csr_mepc_i`) -> IDLE.
- Return PC and cause latched at detection; later input changes are ignored until IDLE.
- `hold_flag_o` = (state != IDLE) or detection this cycle; combinational so the detecting cycle is frozen.
- `we_o` high only in SAVE_* and RESTORE_MSTATUS; `waddr_o`/`data_o` zero when `we_o` low.

## Timing
- Reset: state IDLE; `hold_flag_o`, `we_o`, `int_assert_o` = 0; `waddr_o`, `data_o` = 0; `int_addr_o` = `RESET_ADDR`; latched PC/cause cleared.
- Trap: detection at cycle N; CSR writes N+1, N+2, N+3; `int_assert_o` at N+4; `hold_flag_o` high N..N+4, low N+5.
- mret: write at N+1, redirect N+2, hold high N..N+2.
- `int_assert_o` is exactly one cycle; `int_addr_o` valid only that cycle, `RESET_ADDR` otherwise.
- Interrupt during a trap/mret sequence: ignored; re-evaluated in IDLE (level-sensitive, MIE now 0 after trap).
- Sync instruction and interrupt same cycle: sync wins.
- `rst` mid-sequence: next cycle IDLE, no further CSR writes or redirect.

## Structure
- Shared core package holds: CSR addresses (MSTATUS 12'h300, MTVEC 12'h305, MEPC 12'h341, MCAUSE 12'h342), ECALL/EBREAK/MRET encodings, cause constants, MIE/MPIE bit indices, state enum type.
- Single module; no sub-module.

## Test plan
- ecall at PC 0x100, mtvec 0x200, mstatus 0x8: writes mepc=0x100, mcause=11, mstatus=0x80 on N+1..N+3; `int_assert_o` with 0x200 at N+4; hold N..N+4.
- mret, mepc 0x104, mstatus 0x80: write mstatus=0x88 at N+1; redirect to 0x104 at N+2.
- `int_flag_i`=0x01, MIE=1, `jump_en_i`=1 to 0x300: mepc=0x300, mcause=0x8000_0007.
- `int_flag_i`=0x04 with MIE=0: no hold, no writes; set MIE -> trap with cause 0x8000_000B.
- ebreak and `int_flag_i`=0x01 same cycle: cause 3; interrupt not taken during sequence.
- `rst` at N+2 of a trap: from N+3 all outputs at reset values, no mstatus write.
